nco_quad_dac: RTL

- Parametrised quadrature NCO with a built-in DAC formatter, driving the two 6-bit DAC buses from `pll_clock`.
- Core: phase accumulator, quarter-wave sine lookup and signed-to-offset-binary conversion.
- Adds runtime frequency loading (valid/ready), phase offset, 180° phase flip (`pi`, for BPSK) and synchronous phase clear.

---
 rtl/nco_quad_dac.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nco_quad_dac.sv
// -----------------------------------------------------------------------------
// nco_quad_dac
// Quadrature numerically controlled oscillator with an offset-binary DAC
// formatter. A phase accumulator drives two quarter-wave sine lookups
// (sine and cosine). Their signed samples are re-biased to midscale for a
// pair of unipolar DAC buses.
//
// Pipeline (one register per stage, all clocked by pll_clock):
//   stage 1  phase accumulator + tuning-word shadow/commit logic
//   stage 2  truncated phase + phase_offset + optional 180 degree flip
//   stage 3  quarter-wave fold and table lookup (sine and cosine)
//   stage 4  signed sample and offset-binary DAC output registers
//
// reset_n asserts asynchronously. It must be released synchronously to
// pll_clock, so the upstream reset generator owns the release synchronizer.
// out_valid counts edges from that release.
// -----------------------------------------------------------------------------
module nco_quad_dac #(
    parameter int unsigned      ACC_W     = 32,
    parameter int unsigned      PHASE_W   = 8,
    parameter int unsigned      AMP_W     = 4,
    parameter int unsigned      DAC_W     = 6,
    parameter logic [ACC_W-1:0] FTW_RESET = '0
) (
    input  logic                    pll_clock,
    input  logic                    reset_n,
    input  logic                    clk_en,
    input  logic                    pi,
    input  logic                    sync_clear,
    input  logic [PHASE_W-1:0]      phase_offset,
    input  logic [ACC_W-1:0]        ftw_in,
    input  logic                    ftw_valid,
    output logic                    ftw_ready,
    output logic signed [AMP_W-1:0] sin_out,
    output logic signed [AMP_W-1:0] cos_out,
    output logic [DAC_W-1:0]        dac_zero,
    output logic [DAC_W-1:0]        dac_one,
    output logic                    out_valid
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    // Index bits inside one quadrant, and the number of steps per quadrant.
    localparam int unsigned QW   = PHASE_W - 2;
    localparam int unsigned Q    = 2 ** QW;
    // The table index must reach Q itself (the peak), so it needs one more bit.
    localparam int unsigned IW   = QW + 1;
    // The table stores magnitudes only. The sign comes from the quadrant.
    localparam int unsigned MW   = AMP_W - 1;
    localparam int          PEAK = 2 ** (AMP_W - 1) - 1;

    localparam logic [PHASE_W-1:0]    PHASE_HALF = {1'b1, {(PHASE_W-1){1'b0}}};
    localparam logic [PHASE_W-1:0]    PHASE_QTR  = PHASE_W'(Q);
    localparam logic [DAC_W-1:0]      DAC_MID    = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic signed [AMP_W-1:0] AMP_PEAK = AMP_W'(PEAK);

    // Reject parameter sets the fold and the DAC bias cannot represent.
    if (PHASE_W < 3 || PHASE_W > ACC_W) begin : g_bad_phase_w
        $error("nco_quad_dac: PHASE_W must satisfy 3 <= PHASE_W <= ACC_W");
    end
    if (DAC_W < AMP_W + 1 || AMP_W < 2) begin : g_bad_amp_w
        $error("nco_quad_dac: need AMP_W >= 2 and DAC_W >= AMP_W + 1");
    end

    // -------------------------------------------------------------------------
    // Quarter-wave table, computed at elaboration time
    // -------------------------------------------------------------------------
    // A Taylor series keeps the generator free of library math calls. On
    // [0, pi/2], twelve terms are far beyond the precision any AMP_W needs.
    function automatic logic [MW-1:0] sine_entry(input int k);
        real x;
        real term;
        real sum;
        x    = 3.14159265358979323846 * real'(k) / (2.0 * real'(Q));
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        // Every sample is non-negative, so adding one half and truncating
        // rounds to the nearest integer.
        return MW'($rtoi(sum * real'(PEAK) + 0.5));
    endfunction

    logic [MW-1:0] sine_table [Q+1];

    for (genvar k = 0; k <= int'(Q); k++) begin : g_table
        localparam logic [MW-1:0] ENTRY = sine_entry(k);
        assign sine_table[k] = ENTRY;
    end

    // Map a full-circle phase to a first-quadrant table index. In quadrants
    // 1 and 3 the table is read mirrored (Q - i).
    function automatic logic [IW-1:0] fold_index(input logic [PHASE_W-1:0] ph);
        logic [QW-1:0] i;
        i = ph[QW-1:0];
        if (ph[PHASE_W-2]) begin
            return IW'(Q) - IW'(i);
        end
        return IW'(i);
    endfunction

    // Apply the half-circle sign to a table magnitude.
    function automatic logic signed [AMP_W-1:0] apply_sign(input logic [MW-1:0] mag,
                                                           input logic          neg);
        logic signed [AMP_W-1:0] ext;
        ext = $signed({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    // Shift a signed sample to offset binary centred on DAC midscale.
    function automatic logic [DAC_W-1:0] to_offset_binary(input logic signed [AMP_W-1:0] s);
        return {{(DAC_W-AMP_W){s[AMP_W-1]}}, s} + DAC_MID;
    endfunction

    // -------------------------------------------------------------------------
    // Stage 1: accumulator and tuning-word handshake
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] active_ftw;
    logic [ACC_W-1:0] shadow_ftw;

    // ftw_ready low means the shadow holds a word waiting for commit. A word
    // commits on the next enabled edge. Using non-blocking assignment means
    // the accumulator still adds the old word on that edge.
    // NOTE: sequential state uses <= only, so every register in this block
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            active_ftw <= FTW_RESET;
            shadow_ftw <= '0;
            ftw_ready  <= 1'b1;
        end else begin
            if (sync_clear) begin
                acc <= '0;
            end else if (clk_en) begin
                acc <= acc + active_ftw;
            end

            if (ftw_valid && ftw_ready) begin
                shadow_ftw <= ftw_in;
                ftw_ready  <= 1'b0;
            end else if (!ftw_ready && clk_en) begin
                active_ftw <= shadow_ftw;
                ftw_ready  <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: phase truncation, offset and flip
    // -------------------------------------------------------------------------
    logic [PHASE_W-1:0] phase_next;
    logic [PHASE_W-1:0] sin_phase;
    logic [PHASE_W-1:0] cos_phase;

    // The sum wraps modulo 2^PHASE_W by construction, which is the intended
    // circular phase arithmetic.
    // NOTE: an always_comb output assigned on every path cannot infer a latch.
    always_comb begin
        phase_next = acc[ACC_W-1 -: PHASE_W] + phase_offset;
        if (pi) begin
            phase_next = phase_next + PHASE_HALF;
        end
    end

    // Register the sine phase and derive the cosine phase a quarter ahead.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            sin_phase <= '0;
            cos_phase <= PHASE_QTR;
        end else begin
            sin_phase <= phase_next;
            cos_phase <= phase_next + PHASE_QTR;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: quarter-wave fold and lookup
    // -------------------------------------------------------------------------
    logic [IW-1:0]           sin_idx;
    logic [IW-1:0]           cos_idx;
    logic signed [AMP_W-1:0] sin_sample;
    logic signed [AMP_W-1:0] cos_sample;
    logic signed [AMP_W-1:0] sin_s3;
    logic signed [AMP_W-1:0] cos_s3;

    // Fold both phases into the first quadrant, look them up, and restore the
    // sign from the phase MSB.
    always_comb begin
        sin_idx    = fold_index(sin_phase);
        cos_idx    = fold_index(cos_phase);
        sin_sample = apply_sign(sine_table[sin_idx], sin_phase[PHASE_W-1]);
        cos_sample = apply_sign(sine_table[cos_idx], cos_phase[PHASE_W-1]);
    end

    // Register the looked-up samples. Their reset values are the phase-0
    // point (sin 0, cos +peak).
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            sin_s3 <= '0;
            cos_s3 <= AMP_PEAK;
        end else begin
            sin_s3 <= sin_sample;
            cos_s3 <= cos_sample;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 4: output registers
    // -------------------------------------------------------------------------
    // Publish the signed samples and their offset-binary DAC codes. The
    // outputs read zero and midscale until the first edge after reset.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            sin_out  <= '0;
            cos_out  <= '0;
            dac_zero <= DAC_MID;
            dac_one  <= DAC_MID;
        end else begin
            sin_out  <= sin_s3;
            cos_out  <= cos_s3;
            dac_zero <= to_offset_binary(sin_s3);
            dac_one  <= to_offset_binary(cos_s3);
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline-primed flag
    // -------------------------------------------------------------------------
    logic [1:0] prime_cnt;

    // Raise out_valid on the fourth edge after reset release and keep it high.
    // A sync_clear only restarts the phase, so it leaves out_valid alone.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
            out_valid <= 1'b0;
        end else if (!out_valid) begin
            prime_cnt <= prime_cnt + 2'd1;
            if (prime_cnt == 2'd3) begin
                out_valid <= 1'b1;
            end
        end
    end

endmodule
